wb_writer: RTL and testbench
============================

# wb_writer

Write-back stage that drives the register file's single write port (`we`/`waddr`/`wdata`). It merges two result producers into one port: the ALU, which can be stalled, and the load unit, which is never stalled. ALU results go through a small FIFO. The block also keeps a 32-bit pending-write scoreboard that the issue stage reads to detect RAW hazards.

## Interface
- `ALU_FIFO_DEPTH`, default 2: ALU result FIFO entries; power of two, minimum 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous reset, active-low (0 = reset).
- `rdy` input 1: global ready; when low, the block freezes.
- `alu_valid` input 1: ALU result valid.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `alu_ready` output 1: ALU handshake ready.
- `ld_valid` input 1: load result valid.
- `ld_rd` input 5: load destination register.
- `ld_data` input 32: load result.
- `ld_ready` output 1: load handshake ready.
- `alloc_valid` input 1: issue stage claims a destination register.
- `alloc_rd` input 5: register being claimed.
- `we` output 1: register-file write enable.
- `waddr` output 5: register-file write address.
- `wdata` output 32: register-file write data.
- `busy_mask` output 32: bit i set = write to xi pending.

## Operation
- **Handshakes.** A transfer occurs on a rising edge with valid & ready sampled high.
  - `ld_ready` = `rdy`.
  - `alu_ready` = `rdy` & FIFO not full.
  - Both ready outputs are 0 while `rst`=0.
- **ALU path.** An accepted ALU result is pushed into the FIFO.
- **Output selection, each cycle with `rdy`=1** (in priority order):
  1. Load accepted this cycle → output register loads it.
  2. Else FIFO non-empty → pop head into output register.
  3. Else `we` is loaded with 0.
- **x0 writes.** A result with rd=0 is accepted, popped and handshaken normally, but it produces `we`=0.
- **Output register.** `we`, `waddr` and `wdata` are registered outputs. `waddr` and `wdata` hold their last values when `we`=0.
- **Scoreboard.**
  - `alloc_valid` & `rdy` & `alloc_rd`≠0 sets `busy_mask[alloc_rd]` at the edge.
  - `we`=1 clears `busy_mask[waddr]` at the edge.
  - If set and clear hit the same index in the same cycle, set wins.
  - `busy_mask[0]` is always 0.
- **Stall.** With `rdy`=0:
  - FIFO, output register and scoreboard hold.
  - No transfers occur.
  - `we` holds its value; the register file ignores it because it is gated by `rdy`.
- **Reset.** While `rst`=0 (and asynchronously on entry):
  - FIFO emptied.
  - `we`=0, `waddr`=0, `wdata`=0, `busy_mask`=0.
  - Reset asserted mid-operation discards all queued results.

## Timing
- Load latency: accepted at edge N → `we` high during cycle N to N+1, written into the register file at edge N+1.
- ALU latency, FIFO empty, no load competing: pushed at edge N, popped at edge N+1 → `we` during N+1 to N+2.
- FIFO full: `alu_ready`=0 in the same cycle, combinationally.
- Push and pop in the same cycle on a full FIFO:
  - `alu_ready` stays 0.
  - No push occurs, because readiness is computed from the pre-pop state.
- Continuous loads starve the ALU path. This is acceptable: the load unit guarantees gaps.
- Pointer wrap: read and write pointers are log2(`ALU_FIFO_DEPTH`)+1 bits.
  - full = MSBs differ, remaining bits equal.
  - empty = pointers equal.

## Configuration
- `WB_ALU_BYPASS_EN`, defined:
  - An ALU result accepted while the FIFO is empty and no load is accepted loads the output register directly at the accept edge; it is not pushed.
  - ALU latency becomes 1, the same as loads.
  - If the FIFO is non-empty, results still queue, so ordering is preserved.
- Undefined: every ALU result passes through the FIFO, giving a minimum latency of 2.

## Structure
- Use the shared defines header for `RegAddrBus` (5 bits), `RegBus` (32 bits), `RegNum` and `ZeroWord`. Add `WbFifoDepth` there.
- One sub-module: `wb_fifo`, a synchronous FIFO with push/pop, full/empty, and the same asynchronous active-low reset.
- Arbitration, output register and scoreboard stay in `wb_writer`.

## Test plan
- **Reset.** Hold `rst`=0 with random inputs → `we`=0, `busy_mask`=0, both ready outputs 0. Release reset → `ld_ready`=1, `alu_ready`=1.
- **Single load.** Load rd=5, data 0xDEADBEEF, accepted at edge N, with x5 allocated earlier:
  - Cycle after N: `we`=1, `waddr`=5, `wdata`=0xDEADBEEF.
  - After edge N+1: `busy_mask[5]`=0.
- **Collision.** ALU rd=3 (0x11) and load rd=4 (0x22) accepted in the same cycle → x4 written first, x3 on the next cycle. With bypass undefined, x3 appears two cycles after accept.
- **Backpressure.** Load valid for 4 cycles while pushing 3 ALU results:
  - `alu_ready` drops after 2 pushes.
  - FIFO drains in order after the loads end.
  - No result is lost or duplicated.
- **x0 and scoreboard race.** ALU rd=0 → handshake completes, `we` never goes to 1. Alloc rd=7 in the same cycle that `we` writes x7 → `busy_mask[7]`=1 afterwards.
- **Stall / mid-op reset.** Queue 2 ALU results, then drop `rdy` for 3 cycles → outputs and FIFO frozen. Then assert `rst` → FIFO empties, `we`=0, no stale writes after release.

Source files
------------

// File: rtl/wb_writer_pkg.sv
// Shared register-file definitions and write-back types for the wb_writer slice.
// Optional feature macro used by this slice: WB_ALU_BYPASS_EN.
package wb_writer_pkg;

    localparam int          RegAddrBus  = 5;
    localparam int          RegBus      = 32;
    localparam int          RegNum      = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          WbFifoDepth = 2;

    typedef struct packed {
        logic [RegAddrBus-1:0] rd;
        logic [RegBus-1:0]     data;
    } wb_entry_t;

    // One-hot scoreboard bit for a register index.
    function automatic logic [RegNum-1:0] reg_bit(input logic [RegAddrBus-1:0] r);
        reg_bit = {{(RegNum-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for queued ALU results; pointers carry one extra wrap bit.
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = WbFifoDepth
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    wb_entry_t   mem_r [DEPTH];

    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty = (wptr_r == rptr_r);
    assign dout  = mem_r[rptr_r[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push && !full)
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            if (pop && !empty)
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Entry storage, cleared on reset so no stale result can reappear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_r[i] <= '{rd: 5'd0, data: ZeroWord};
        end else if (push && !full) begin
            mem_r[wptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: merges load and ALU results onto the register-file write port
// and tracks pending writes. Optional direct ALU path under WB_ALU_BYPASS_EN.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = WbFifoDepth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  alu_valid,
    input  logic [RegAddrBus-1:0] alu_rd,
    input  logic [RegBus-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [RegAddrBus-1:0] ld_rd,
    input  logic [RegBus-1:0]     ld_data,
    output logic                  ld_ready,
    input  logic                  alloc_valid,
    input  logic [RegAddrBus-1:0] alloc_rd,
    output logic                  we,
    output logic [RegAddrBus-1:0] waddr,
    output logic [RegBus-1:0]     wdata,
    output logic [RegNum-1:0]     busy_mask
);

    logic                  fifo_full_s, fifo_empty_s;
    logic                  ld_fire_s, alu_fire_s, byp_s, push_s, pop_s;
    logic                  we_nxt_s;
    wb_entry_t             fifo_dout_s, sel_s;
    logic [RegNum-1:0]     busy_nxt_s;
    logic                  we_r;
    logic [RegAddrBus-1:0] waddr_r;
    logic [RegBus-1:0]     wdata_r;
    logic [RegNum-1:0]     busy_r;

    assign ld_ready   = rst & rdy;
    assign alu_ready  = rst & rdy & ~fifo_full_s;
    assign ld_fire_s  = ld_valid & ld_ready;
    assign alu_fire_s = alu_valid & alu_ready;

`ifdef WB_ALU_BYPASS_EN
    assign byp_s = alu_fire_s & fifo_empty_s & ~ld_fire_s;
`else
    assign byp_s = 1'b0;
`endif

    assign push_s = alu_fire_s & ~byp_s;
    // Loads always win the port; the FIFO only drains in load-free cycles.
    assign pop_s  = rdy & ~ld_fire_s & ~fifo_empty_s;

    wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   ('{rd: alu_rd, data: alu_data}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Result selection for the output register.
    always_comb begin
        sel_s    = fifo_dout_s;
        we_nxt_s = 1'b0;
        if (ld_fire_s) begin
            sel_s    = '{rd: ld_rd, data: ld_data};
            we_nxt_s = (ld_rd != 5'd0);
        end else if (byp_s) begin
            sel_s    = '{rd: alu_rd, data: alu_data};
            we_nxt_s = (alu_rd != 5'd0);
        end else if (!fifo_empty_s) begin
            sel_s    = fifo_dout_s;
            we_nxt_s = (fifo_dout_s.rd != 5'd0);
        end else begin
            we_nxt_s = 1'b0;
        end
    end

    // Scoreboard next state: the retiring write clears first so a same-index claim wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (we_r)
            busy_nxt_s = busy_nxt_s & ~reg_bit(waddr_r);
        else
            busy_nxt_s = busy_nxt_s;
        if (alloc_valid && (alloc_rd != 5'd0))
            busy_nxt_s = busy_nxt_s | reg_bit(alloc_rd);
        else
            busy_nxt_s = busy_nxt_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Output register; address and data only move on a real write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            waddr_r <= 5'd0;
            wdata_r <= ZeroWord;
        end else if (rdy) begin
            we_r <= we_nxt_s;
            if (we_nxt_s) begin
                waddr_r <= sel_s.rd;
                wdata_r <= sel_s.data;
            end
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_r <= {RegNum{1'b0}};
        else if (rdy)
            busy_r <= busy_nxt_s;
    end

    assign we        = we_r;
    assign waddr     = waddr_r;
    assign wdata     = wdata_r;
    assign busy_mask = busy_r;

endmodule

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer (default build, FIFO depth 2).
module tb_wb_writer;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        alu_valid, ld_valid, alloc_valid;
    logic [4:0]  alu_rd, ld_rd, alloc_rd;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, we;
    logic [4:0]  waddr;
    logic [31:0] wdata, busy_mask;
    int          tests = 0;
    int          fails = 0;

    wb_writer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .we(we), .waddr(waddr), .wdata(wdata), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d);
        chk({tag, ".we"}, {31'd0, we}, {31'd0, e_we});
        chk({tag, ".waddr"}, {27'd0, waddr}, {27'd0, e_a});
        chk({tag, ".wdata"}, wdata, e_d);
    endtask

    initial begin
        // Reset with random-looking inputs applied
        rst = 1'b0; rdy = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = $urandom;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = $urandom;
        alloc_valid = 1'b1; alloc_rd = 5'd12;
        tick(); tick(); tick();
        chk("rst.we", {31'd0, we}, 32'd0);
        chk("rst.busy", busy_mask, 32'd0);
        chk("rst.ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst.alu_ready", {31'd0, alu_ready}, 32'd0);
        alu_valid = 1'b0; ld_valid = 1'b0; alloc_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel.ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rel.alu_ready", {31'd0, alu_ready}, 32'd1);

        // Single load to a previously allocated register
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        tick();
        alloc_valid = 1'b0;
        chk("ld.busy_set", busy_mask, 32'h0000_0020);
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_valid = 1'b0;
        chk_out("ld.out", 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("ld.busy_pending", busy_mask, 32'h0000_0020);
        tick();
        chk("ld.busy_clr", busy_mask, 32'd0);
        chk_out("ld.hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

        // Collision: load wins, ALU follows one cycle later
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h22;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk_out("col.ld", 1'b1, 5'd4, 32'h22);
        tick();
        chk_out("col.alu", 1'b1, 5'd3, 32'h11);
        tick();
        chk("col.idle", {31'd0, we}, 32'd0);

        // Lone ALU result: two-cycle latency through the FIFO
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        chk("alu.lat1", {31'd0, we}, 32'd0);
        tick();
        chk_out("alu.lat2", 1'b1, 5'd9, 32'h99);
        tick();

        // Backpressure: four loads against three ALU results
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hB0;
        chk("bp.rdy1", {31'd0, alu_ready}, 32'd1);
        tick();
        chk_out("bp.ld10", 1'b1, 5'd10, 32'hA0);
        ld_rd = 5'd11; ld_data = 32'hA1; alu_rd = 5'd21; alu_data = 32'hB1;
        chk("bp.rdy2", {31'd0, alu_ready}, 32'd1);
        tick();
        chk_out("bp.ld11", 1'b1, 5'd11, 32'hA1);
        ld_rd = 5'd12; ld_data = 32'hA2; alu_rd = 5'd22; alu_data = 32'hB2;
        chk("bp.full3", {31'd0, alu_ready}, 32'd0);
        tick();
        chk_out("bp.ld12", 1'b1, 5'd12, 32'hA2);
        ld_rd = 5'd13; ld_data = 32'hA3;
        chk("bp.full4", {31'd0, alu_ready}, 32'd0);
        tick();
        chk_out("bp.ld13", 1'b1, 5'd13, 32'hA3);
        ld_valid = 1'b0;
        chk("bp.full_pop", {31'd0, alu_ready}, 32'd0);
        tick();
        chk_out("bp.alu20", 1'b1, 5'd20, 32'hB0);
        chk("bp.rdy_again", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk_out("bp.alu21", 1'b1, 5'd21, 32'hB1);
        tick();
        chk_out("bp.alu22", 1'b1, 5'd22, 32'hB2);
        tick();
        chk("bp.drained", {31'd0, we}, 32'd0);

        // x0 result completes its handshake but never writes
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        chk("x0.ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        tick();
        chk("x0.we_pop", {31'd0, we}, 32'd0);
        tick();
        chk("x0.we_after", {31'd0, we}, 32'd0);

        // Scoreboard race: claim x7 in the cycle its write retires
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        tick();
        ld_valid = 1'b0;
        chk_out("race.wr", 1'b1, 5'd7, 32'h77);
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_valid = 1'b0;
        chk("race.busy", busy_mask, 32'h0000_0080);

        // Queue two ALU results behind loads, then stall
        ld_valid = 1'b1; ld_rd = 5'd14; ld_data = 32'hC0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
        tick();
        ld_rd = 5'd15; ld_data = 32'hC1; alu_rd = 5'd2; alu_data = 32'h102;
        tick();
        chk_out("stall.pre", 1'b1, 5'd15, 32'hC1);
        rdy = 1'b0; ld_valid = 1'b0; alu_rd = 5'd3; alu_data = 32'h103;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall.hold", 1'b1, 5'd15, 32'hC1);
            chk("stall.alu_ready", {31'd0, alu_ready}, 32'd0);
            chk("stall.ld_ready", {31'd0, ld_ready}, 32'd0);
            chk("stall.busy", busy_mask, 32'h0000_0080);
        end
        alu_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_out("mrst.out", 1'b0, 5'd0, 32'd0);
        chk("mrst.busy", busy_mask, 32'd0);
        tick();
        rst = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst.no_stale", {31'd0, we}, 32'd0);
        end
        chk("mrst.alu_ready", {31'd0, alu_ready}, 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h2;
        tick();
        ld_valid = 1'b0;
        chk_out("mrst.alive", 1'b1, 5'd2, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
